// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, owner
// encoding, default base address and byte-address to word-index conversion.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    typedef enum logic {
        OwnCpu,
        OwnLdr
    } owner_e;

    localparam int unsigned DefaultBaseAddr = 1024;

    // Full-width word offset; callers truncate to their index width so that
    // out-of-range addresses wrap modulo the memory depth.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
        logic [31:0] offs;
        offs = addr - base;
        return offs >> 2;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter between the CPU and loader ports; the last
// grant only advances when a grant is issued while enabled.
module rr_arbiter_2
    import mem_ctrl_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_en,
    input  logic   i_req_cpu,
    input  logic   i_req_ldr,
    output logic   o_gnt_valid,
    output owner_e o_gnt_owner
);

    owner_e r_last;

    always_comb begin
        o_gnt_valid = i_en & (i_req_cpu | i_req_ldr);
        if (i_req_cpu && i_req_ldr) begin
            // Tie goes to whoever did not win last time.
            o_gnt_owner = (r_last == OwnLdr) ? OwnCpu : OwnLdr;
        end else if (i_req_cpu) begin
            o_gnt_owner = OwnCpu;
        end else begin
            o_gnt_owner = OwnLdr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= OwnLdr;
        end else if (o_gnt_valid) begin
            r_last <= o_gnt_owner;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and the
// loader, inserting fixed wait states and freezing the pipeline via cpu_ready.
module data_mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter  int unsigned Depth      = 64,
    parameter  int unsigned BaseAddr   = DefaultBaseAddr,
    parameter  int unsigned WaitCycles = 2,
    localparam int unsigned IdxW       = $clog2(Depth)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cpu_r_en,
    input  logic            i_cpu_w_en,
    input  logic [31:0]     i_cpu_addr,
    input  logic [31:0]     i_cpu_wdata,
    output logic [31:0]     o_cpu_rdata,
    output logic            o_cpu_ready,
    input  logic            i_ldr_req,
    input  logic            i_ldr_w_en,
    input  logic [31:0]     i_ldr_addr,
    input  logic [31:0]     i_ldr_wdata,
    output logic [31:0]     o_ldr_rdata,
    output logic            o_ldr_ack,
    output logic            o_mem_r_en,
    output logic            o_mem_w_en,
    output logic [IdxW-1:0] o_mem_addr,
    output logic [31:0]     o_mem_wdata,
    input  logic [31:0]     i_mem_rdata
);

    localparam int unsigned CntW = 4;

    state_e          r_state, w_state_d;
    owner_e          r_owner, w_owner_d;
    logic            r_op_wr, w_op_wr_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [IdxW-1:0] r_mem_addr, w_addr_d;
    logic [31:0]     r_mem_wdata, w_wdata_d;
    logic            r_mem_r_en, r_mem_w_en;
    logic [31:0]     r_cpu_rdata, r_ldr_rdata;
    logic            r_ldr_ack;
    logic            w_capture;
    logic            w_cpu_req;
    logic            w_gnt_valid;
    owner_e          w_gnt_owner;
    logic [IdxW-1:0] w_cpu_idx, w_ldr_idx;

    assign w_cpu_req = i_cpu_r_en | i_cpu_w_en;
    assign w_cpu_idx = IdxW'(addr_to_idx(i_cpu_addr, BaseAddr));
    assign w_ldr_idx = IdxW'(addr_to_idx(i_ldr_addr, BaseAddr));

    rr_arbiter_2 u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (r_state == StIdle),
        .i_req_cpu   (w_cpu_req),
        .i_req_ldr   (i_ldr_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_owner (w_gnt_owner)
    );

    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_op_wr_d = r_op_wr;
        w_cnt_d   = r_cnt;
        w_addr_d  = r_mem_addr;
        w_wdata_d = r_mem_wdata;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    w_owner_d = w_gnt_owner;
                    if (w_gnt_owner == OwnCpu) begin
                        // r_en together with w_en still counts as a write.
                        w_op_wr_d = i_cpu_w_en;
                        w_addr_d  = w_cpu_idx;
                        w_wdata_d = i_cpu_wdata;
                    end else begin
                        w_op_wr_d = i_ldr_w_en;
                        w_addr_d  = w_ldr_idx;
                        w_wdata_d = i_ldr_wdata;
                    end
                    w_cnt_d   = CntW'(WaitCycles - 1);
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Strobes are registered from next state so the write pulse lands on the
    // final ACCESS cycle and a reset before it never lets it out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_owner     <= OwnCpu;
            r_op_wr     <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_r_en  <= 1'b0;
            r_mem_w_en  <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_ldr_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_owner     <= w_owner_d;
            r_op_wr     <= w_op_wr_d;
            r_cnt       <= w_cnt_d;
            r_mem_addr  <= w_addr_d;
            r_mem_wdata <= w_wdata_d;
            r_mem_r_en  <= (w_state_d == StAccess) & ~w_op_wr_d;
            r_mem_w_en  <= (w_state_d == StAccess) & w_op_wr_d & (w_cnt_d == '0);
            r_ldr_ack   <= (w_state_d == StDone) & (w_owner_d == OwnLdr);
            if (w_capture && !r_op_wr && r_owner == OwnCpu) begin
                r_cpu_rdata <= i_mem_rdata;
            end
            if (w_capture && !r_op_wr && r_owner == OwnLdr) begin
                r_ldr_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_cpu_ready = ~i_rst_n | ~w_cpu_req | ((r_state == StDone) & (r_owner == OwnCpu));
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ldr_rdata = r_ldr_rdata;
    assign o_ldr_ack   = r_ldr_ack;
    assign o_mem_r_en  = r_mem_r_en;
    assign o_mem_w_en  = r_mem_w_en;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
